// File: rtl/period_meter_if.sv
// period_meter_if: groups the measured signal, the start request and the
// measurement results of period_meter into one bundle.
//   I_SIG      slow asynchronous square wave to measure
//   start      one-shot measurement request
//   O_PERIOD   last rising-to-rising distance, in I_CLK cycles
//   O_HIGH     last rising-to-falling distance, in I_CLK cycles
//   O_VALID    one-cycle pulse, new results present
//   O_BUSY     measurement in progress
//   O_TIMEOUT  one-cycle pulse, measurement aborted
// master: the requester (drives I_SIG/start); slave: the meter itself.
interface period_meter_if #(
   parameter int CNT_W = 27
);
   logic             I_SIG;
   logic             start;
   logic [CNT_W-1:0] O_PERIOD;
   logic [CNT_W-1:0] O_HIGH;
   logic             O_VALID;
   logic             O_BUSY;
   logic             O_TIMEOUT;

   modport master (
      output I_SIG, start,
      input  O_PERIOD, O_HIGH, O_VALID, O_BUSY, O_TIMEOUT
   );

   modport slave (
      input  I_SIG, start,
      output O_PERIOD, O_HIGH, O_VALID, O_BUSY, O_TIMEOUT
   );
endinterface

// File: rtl/period_meter.sv
// period_meter: one-shot measurement of the period and high time of a slow
// asynchronous square wave, counted in I_CLK cycles.
//   I_CLK  system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    period_meter_if slave: I_SIG/start in, O_PERIOD/O_HIGH/O_VALID/
//          O_BUSY/O_TIMEOUT out (all outputs registered)
// Parameters: CNT_W counter/result width, MAX_COUNT timeout for any single
// wait (must fit in CNT_W bits).
module period_meter #(
   parameter int               CNT_W     = 27,
   parameter logic [CNT_W-1:0] MAX_COUNT = {CNT_W{1'b1}}
) (
   input logic           I_CLK,
   input logic           rst_n,
   period_meter_if.slave bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_MEASURE = 2'd2;

   logic             sync1, sync2, dly;
   logic             rise, fall;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] high_cap;
   logic             high_seen;
   logic [CNT_W-1:0] period_q, high_q;
   logic             valid_q, busy_q, timeout_q;

   // Two-flop synchronizer plus one delay flop. Every edge sees the same
   // latency, so it drops out of all measured distances.
   always_ff @(posedge I_CLK or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         dly   <= 1'b0;
      end else begin
         sync1 <= bus.I_SIG;
         sync2 <= sync1;
         dly   <= sync2;
      end
   end

   assign rise = sync2 & ~dly;
   assign fall = ~sync2 & dly;

   always_ff @(posedge I_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         high_cap  <= '0;
         high_seen <= 1'b0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               // Edges in the accepting cycle are ignored: IDLE never looks
               // at rise/fall.
               if (bus.start) begin
                  state  <= S_WAIT;
                  busy_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (rise) begin
                  state     <= S_MEASURE;
                  cnt       <= {{(CNT_W-1){1'b0}}, 1'b1};
                  high_seen <= 1'b0;
               end else if (cnt == MAX_COUNT) begin
                  state     <= S_IDLE;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_MEASURE: begin
               // cnt equals the distance from the opening rise, so it is
               // captured directly as the result.
               if (fall && !high_seen) begin
                  high_cap  <= cnt;
                  high_seen <= 1'b1;
               end
               // rise wins over timeout when both land on the same cycle
               if (rise) begin
                  state    <= S_IDLE;
                  busy_q   <= 1'b0;
                  period_q <= cnt;
                  high_q   <= high_cap;
                  valid_q  <= 1'b1;
                  cnt      <= '0;
               end else if (cnt == MAX_COUNT) begin
                  state     <= S_IDLE;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
               cnt    <= '0;
            end
         endcase
      end
   end

   assign bus.O_PERIOD  = period_q;
   assign bus.O_HIGH    = high_q;
   assign bus.O_VALID   = valid_q;
   assign bus.O_BUSY    = busy_q;
   assign bus.O_TIMEOUT = timeout_q;

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous square wave, such as a divided clock produced elsewhere in the design, in cycles of the system clock `I_CLK`. It is the receiving end of the clock-divider path. It recovers the divide count from the slow signal, for self-check of divider settings on the board and for display and debug logic. Measurement is one-shot per `start` request.

## Interface
Parameters:
- `CNT_W`, default 27: width of the internal counter and of the measurement outputs.
- `MAX_COUNT`, default 2^27-1: timeout limit, in `I_CLK` cycles, for any single wait. Must be ≤ 2^CNT_W-1.

Ports:
- `I_CLK`, input, 1: system clock, rising-edge active.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `I_SIG`, input, 1: slow signal to measure; asynchronous to `I_CLK`.
- `start`, input, 1: measurement request; sampled only in IDLE.
- `O_PERIOD`, output, CNT_W: last measured rising-to-rising distance, in cycles.
- `O_HIGH`, output, CNT_W: last measured rising-to-falling distance, in cycles.
- `O_VALID`, output, 1: one-cycle pulse; new `O_PERIOD`/`O_HIGH` are valid.
- `O_BUSY`, output, 1: high in any state other than IDLE.
- `O_TIMEOUT`, output, 1: one-cycle pulse; measurement aborted.

## Operation
- `I_SIG` passes through a 2-flop synchronizer, then through a delay flop for edge detection.
  - `rise` = synced & ~delayed.
  - `fall` = ~synced & delayed.
- The synchronizer latency is identical for all edges, so it cancels out of every distance.
- States:
  - IDLE: counter held at 0. `start`=1 → WAIT_RISE; counter cleared to 0.
  - WAIT_RISE: counter +1 each cycle.
    - `rise` → MEASURE; counter <= 1; high_seen <= 0.
    - Else if counter==MAX_COUNT → IDLE with timeout.
  - MEASURE: counter +1 each cycle.
    - `fall` while high_seen==0 → high_cap <= counter; high_seen <= 1.
    - `rise` → `O_PERIOD` <= counter; `O_HIGH` <= high_cap; `O_VALID` pulse; → IDLE.
    - Else if counter==MAX_COUNT → IDLE with timeout.
- Result: `O_PERIOD` = t1-t0 and `O_HIGH` = tf-t0, where t0 and t1 are the consecutive `rise` cycles and tf is the first `fall` cycle between them.
- Timeout:
  - `O_TIMEOUT` pulses for one cycle.
  - `O_PERIOD`, `O_HIGH` and `O_VALID` are unchanged or not asserted.
  - Counter is cleared.
- Precedence in the same cycle: `rise` beats timeout, so `rise` with counter==MAX_COUNT completes normally.
- `start` while `O_BUSY`=1 is ignored; it is not queued.
- An edge detected in the same cycle that `start` is accepted is not used. Edge qualification begins the cycle after.
- Counter arithmetic is unsigned CNT_W bits. It never wraps, because timeout fires at MAX_COUNT first.

## Timing
- Reset values: `O_PERIOD`=0, `O_HIGH`=0, `O_VALID`=0, `O_BUSY`=0, `O_TIMEOUT`=0. State is IDLE, counter 0, synchronizer flops 0.
- All outputs are registered. `O_BUSY` goes to 1 the cycle after `start` is accepted.
- On completion at cycle t1:
  - `O_VALID`=1 and the new data appear at t1+1.
  - `O_BUSY`=0 at t1+1.
  - A new `start` is accepted at t1+1.
- Timeout: `start` accepted at cycle s with no `rise` → `O_TIMEOUT`=1 at cycle s+MAX_COUNT+2.
- Latency from a physical `I_SIG` rising edge to its `rise` pulse: 2-3 cycles.
- Asserting `rst_n`=0 mid-measurement immediately forces all reset values. No `O_VALID` or `O_TIMEOUT` pulse is produced.

## Test plan
- Reset: hold `rst_n`=0, toggle `I_SIG` and `start` → all outputs stay 0. Release; `O_BUSY` stays 0 until `start`.
- Divider-shaped input, 5 cycles high / 5 low, phase-random vs `start` → `O_PERIOD`=10, `O_HIGH`=5, single `O_VALID` pulse, then `O_BUSY`=0.
- Asymmetric input, 3 high / 7 low, then 1 high / 1 low → `O_PERIOD`=10, `O_HIGH`=3; then `O_PERIOD`=2, `O_HIGH`=1.
- `MAX_COUNT`=20, `I_SIG` held 0, `start` at cycle s → `O_TIMEOUT` at s+22, `O_PERIOD` keeps its previous value, no `O_VALID`. Repeat with `I_SIG` stuck 1 after one rise → timeout from MEASURE.
- `start` pulsed repeatedly while busy → exactly one `O_VALID` per accepted `start`; measured values unaffected.
- Drop `rst_n` midway through MEASURE (input 50/50 high/low) → outputs return to 0 asynchronously. A fresh `start` then yields `O_PERIOD`=100, `O_HIGH`=50.
